// File: rtl/game_pkg.sv
// Shared button geometry and identifiers for the button press controller.
package game_pkg;

  localparam int unsigned BTN_W = 20;
  localparam int unsigned BTN_H = 10;

  localparam logic [9:0] PURPLE1_X = 10'd172;
  localparam logic [9:0] PURPLE1_Y = 10'd241;
  localparam logic [9:0] PURPLE2_X = 10'd520;
  localparam logic [9:0] PURPLE2_Y = 10'd178;
  localparam logic [9:0] YELLOW_X  = 10'd142;
  localparam logic [9:0] YELLOW_Y  = 10'd322;

  typedef enum logic [1:0] {
    PURPLE1,
    PURPLE2,
    YELLOW
  } button_id_t;

  function automatic logic [9:0] btn_x(button_id_t id);
    logic [9:0] x;
    case (id)
      PURPLE1: x = PURPLE1_X;
      PURPLE2: x = PURPLE2_X;
      default: x = YELLOW_X;
    endcase
    return x;
  endfunction

  function automatic logic [9:0] btn_y(button_id_t id);
    logic [9:0] y;
    case (id)
      PURPLE1: y = PURPLE1_Y;
      PURPLE2: y = PURPLE2_Y;
      default: y = YELLOW_Y;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/button_detect.sv
// Overlap test and per-frame hit filter for one button; the yellow button latches.
// Define BUTTON_DEBOUNCE_EN to require two agreeing frame edges before the hit changes.
module button_detect
  import game_pkg::*;
#(
  parameter int unsigned PLAYER_W = 20,
  parameter int unsigned PLAYER_H = 30,
  parameter button_id_t  BTN_ID   = PURPLE1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_edge_i,
  input  logic [9:0] p1_x_i,
  input  logic [9:0] p1_y_i,
  input  logic [9:0] p2_x_i,
  input  logic [9:0] p2_y_i,
  output logic       hit_o
);

  localparam logic [10:0] BxLo   = {1'b0, btn_x(BTN_ID)};
  localparam logic [10:0] ByLo   = {1'b0, btn_y(BTN_ID)};
  localparam logic [10:0] BxHi   = BxLo + 11'(BTN_W);
  localparam logic [10:0] ByHi   = ByLo + 11'(BTN_H);
  localparam bit          Sticky = (BTN_ID == YELLOW);

  // 11-bit sums so a sprite near the 10-bit edge cannot wrap into a button.
  function automatic logic overlap(logic [9:0] x, logic [9:0] y);
    logic [10:0] xl, xh, yl, yh;
    xl = {1'b0, x};
    yl = {1'b0, y};
    xh = xl + 11'(PLAYER_W);
    yh = yl + 11'(PLAYER_H);
    return (xl < BxHi) && (BxLo < xh) && (yl < ByHi) && (ByLo < yh);
  endfunction

  logic raw;
  logic filt;
  logic hit_q, hit_d;

  assign raw = overlap(p1_x_i, p1_y_i) | overlap(p2_x_i, p2_y_i);

`ifdef BUTTON_DEBOUNCE_EN
  logic raw_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q <= 1'b0;
    end else if (frame_edge_i) begin
      raw_q <= raw;
    end
  end

  assign filt = (raw == raw_q) ? raw : hit_q;
`else
  assign filt = raw;
`endif

  always_comb begin
    hit_d = hit_q;
    if (frame_edge_i) begin
      hit_d = Sticky ? (hit_q | filt) : filt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/button_press_ctrl.sv
// Button press controller: per-frame button sampling and platform offset ramps.
// Optional BUTTON_DEBOUNCE_EN adds a two-frame hit filter inside button_detect.
module button_press_ctrl
  import game_pkg::*;
#(
  parameter int unsigned PLAYER_W     = 20,
  parameter int unsigned PLAYER_H     = 30,
  parameter int unsigned PLATFORM_MAX = 40
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic       is_button_purple_push1,
  output logic       is_button_purple_push2,
  output logic       is_button_push,
  output logic [5:0] purple_offset,
  output logic [5:0] yellow_offset
);

  localparam logic [5:0] OffMax = 6'(PLATFORM_MAX);

  logic       frame_q;
  logic       frame_edge;
  logic       purple1_q, purple2_q, yellow_q;
  logic [5:0] purple_off_q, purple_off_d;
  logic [5:0] yellow_off_q, yellow_off_d;

  assign frame_edge = frame_clk & ~frame_q;

  button_detect #(
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H),
    .BTN_ID  (PURPLE1)
  ) u_purple1 (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_edge_i(frame_edge),
    .p1_x_i      (p1_x),
    .p1_y_i      (p1_y),
    .p2_x_i      (p2_x),
    .p2_y_i      (p2_y),
    .hit_o       (purple1_q)
  );

  button_detect #(
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H),
    .BTN_ID  (PURPLE2)
  ) u_purple2 (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_edge_i(frame_edge),
    .p1_x_i      (p1_x),
    .p1_y_i      (p1_y),
    .p2_x_i      (p2_x),
    .p2_y_i      (p2_y),
    .hit_o       (purple2_q)
  );

  button_detect #(
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H),
    .BTN_ID  (YELLOW)
  ) u_yellow (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_edge_i(frame_edge),
    .p1_x_i      (p1_x),
    .p1_y_i      (p1_y),
    .p2_x_i      (p2_x),
    .p2_y_i      (p2_y),
    .hit_o       (yellow_q)
  );

  // Offsets read the push flops before this edge updates them: one frame of latency.
  always_comb begin
    purple_off_d = purple_off_q;
    yellow_off_d = yellow_off_q;
    if (frame_edge) begin
      if (purple1_q | purple2_q) begin
        if (purple_off_q < OffMax) purple_off_d = purple_off_q + 6'd1;
      end else if (purple_off_q != 6'd0) begin
        purple_off_d = purple_off_q - 6'd1;
      end
      if (yellow_q && (yellow_off_q < OffMax)) begin
        yellow_off_d = yellow_off_q + 6'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q      <= 1'b0;
      purple_off_q <= 6'd0;
      yellow_off_q <= 6'd0;
    end else begin
      frame_q      <= frame_clk;
      purple_off_q <= purple_off_d;
      yellow_off_q <= yellow_off_d;
    end
  end

  assign is_button_purple_push1 = purple1_q;
  assign is_button_purple_push2 = purple2_q;
  assign is_button_push         = yellow_q;
  assign purple_offset          = purple_off_q;
  assign yellow_offset          = yellow_off_q;

endmodule

// File: tb/tb_button_press_ctrl.sv
// Directed self-checking bench for button_press_ctrl (honours BUTTON_DEBOUNCE_EN latency).
module tb_button_press_ctrl;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  localparam logic [9:0] FarX = 10'd600;
  localparam logic [9:0] FarY = 10'd400;

  logic       Clk       = 1'b0;
  logic       Reset     = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] p1_x = FarX, p1_y = FarY, p2_x = FarX, p2_y = FarY;
  logic       push1, push2, ypush;
  logic [5:0] poff, yoff;

  int n_tests = 0;
  int n_fail  = 0;

  button_press_ctrl dut (
    .Clk                   (Clk),
    .Reset                 (Reset),
    .frame_clk             (frame_clk),
    .p1_x                  (p1_x),
    .p1_y                  (p1_y),
    .p2_x                  (p2_x),
    .p2_y                  (p2_y),
    .is_button_purple_push1(push1),
    .is_button_purple_push2(push2),
    .is_button_push        (ypush),
    .purple_offset         (poff),
    .yellow_offset         (yoff)
  );

  always #5 Clk = ~Clk;

  task automatic pulse();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 5;
    if (push1 !== 1'b0) begin n_fail++; $display("FAIL reset_push1 got %b want 0", push1); end
    if (push2 !== 1'b0) begin n_fail++; $display("FAIL reset_push2 got %b want 0", push2); end
    if (ypush !== 1'b0) begin n_fail++; $display("FAIL reset_ypush got %b want 0", ypush); end
    if (poff !== 6'd0) begin n_fail++; $display("FAIL reset_poff got %0d want 0", poff); end
    if (yoff !== 6'd0) begin n_fail++; $display("FAIL reset_yoff got %0d want 0", yoff); end
  endtask

  task automatic test_purple_press();
    do_reset();
    p1_x = 10'd170; p1_y = 10'd225;
    for (int i = 1; i <= Lat; i++) begin
      pulse();
      n_tests++;
      if (push1 !== (i == Lat)) begin
        n_fail++; $display("FAIL press_push1 edge %0d got %b want %b", i, push1, (i == Lat));
      end
    end
    n_tests += 2;
    if (push2 !== 1'b0) begin n_fail++; $display("FAIL press_push2 got %b want 0", push2); end
    if (ypush !== 1'b0) begin n_fail++; $display("FAIL press_ypush got %b want 0", ypush); end
  endtask

  task automatic test_ramp();
    int e;
    do_reset();
    p1_x = 10'd172; p1_y = 10'd241;
    for (int n = 1; n <= 50; n++) begin
      pulse();
      e = (n <= Lat) ? 0 : ((n - Lat > 40) ? 40 : n - Lat);
      n_tests++;
      if (poff !== 6'(e)) begin n_fail++; $display("FAIL ramp_up edge %0d got %0d want %0d", n, poff, e); end
    end
    p1_x = FarX; p1_y = FarY;
    for (int m = 1; m <= 50; m++) begin
      pulse();
      e = (m <= Lat) ? 40 : ((40 - (m - Lat) < 0) ? 0 : 40 - (m - Lat));
      n_tests++;
      if (poff !== 6'(e)) begin n_fail++; $display("FAIL ramp_down edge %0d got %0d want %0d", m, poff, e); end
    end
    n_tests++;
    if (push1 !== 1'b0) begin n_fail++; $display("FAIL ramp_release_push1 got %b want 0", push1); end
  endtask

  task automatic test_yellow();
    int e;
    do_reset();
    p2_x = 10'd140; p2_y = 10'd300;
    pulses(Lat);
    n_tests += 2;
    if (ypush !== 1'b1) begin n_fail++; $display("FAIL yellow_latch got %b want 1", ypush); end
    if (yoff !== 6'd0) begin n_fail++; $display("FAIL yellow_first got %0d want 0", yoff); end
    p2_x = FarX; p2_y = FarY;
    for (int k = 1; k <= 45; k++) begin
      pulse();
      e = (k > 40) ? 40 : k;
      n_tests += 2;
      if (yoff !== 6'(e)) begin n_fail++; $display("FAIL yellow_ramp edge %0d got %0d want %0d", k, yoff, e); end
      if (ypush !== 1'b1) begin n_fail++; $display("FAIL yellow_hold edge %0d got %b want 1", k, ypush); end
    end
    n_tests++;
    if (poff !== 6'd0) begin n_fail++; $display("FAIL yellow_poff got %0d want 0", poff); end
  endtask

  task automatic test_frame_hold();
    do_reset();
    p1_x = 10'd520; p1_y = 10'd178;
    pulses(Lat);
    n_tests += 3;
    if (push2 !== 1'b1) begin n_fail++; $display("FAIL hold_pre_push2 got %b want 1", push2); end
    if (push1 !== 1'b0) begin n_fail++; $display("FAIL hold_pre_push1 got %b want 0", push1); end
    if (poff !== 6'd0) begin n_fail++; $display("FAIL hold_pre_poff got %0d want 0", poff); end
    @(negedge Clk) frame_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i == 0) begin p1_x = FarX; p1_y = FarY; end
      n_tests += 2;
      if (poff !== 6'd1) begin n_fail++; $display("FAIL hold_poff cyc %0d got %0d want 1", i, poff); end
      if (push2 !== 1'b1) begin n_fail++; $display("FAIL hold_push2 cyc %0d got %b want 1", i, push2); end
    end
    frame_clk = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (poff !== 6'd1) begin n_fail++; $display("FAIL hold_after got %0d want 1", poff); end
  endtask

  task automatic test_bounds();
    logic [9:0] bx [10];
    logic [9:0] by [10];
    logic       be [10];
    bx = '{10'd153, 10'd152, 10'd191, 10'd192, 10'd172, 10'd172, 10'd172, 10'd172,
           10'd1010, 10'd170};
    by = '{10'd241, 10'd241, 10'd241, 10'd241, 10'd212, 10'd211, 10'd250, 10'd251,
           10'd1010, 10'd225};
    be = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      p1_x = bx[i]; p1_y = by[i];
      pulses(Lat);
      n_tests++;
      if (push1 !== be[i]) begin
        n_fail++; $display("FAIL bound (%0d,%0d) got %b want %b", bx[i], by[i], push1, be[i]);
      end
    end
    // Both players on purple1 still step the offset by one per frame.
    do_reset();
    p1_x = 10'd172; p1_y = 10'd241; p2_x = 10'd175; p2_y = 10'd230;
    pulses(Lat + 1);
    n_tests += 2;
    if (push1 !== 1'b1) begin n_fail++; $display("FAIL both_push1 got %b want 1", push1); end
    if (poff !== 6'd1) begin n_fail++; $display("FAIL both_poff got %0d want 1", poff); end
    p1_x = FarX; p1_y = FarY;
    pulses(Lat);
    n_tests++;
    if (push1 !== 1'b1) begin n_fail++; $display("FAIL p2_only_push1 got %b want 1", push1); end
    p2_x = FarX; p2_y = FarY;
  endtask

  task automatic test_reset_on_edge();
    do_reset();
    p1_x = 10'd172; p1_y = 10'd241; p2_x = 10'd140; p2_y = 10'd300;
    pulses(Lat + 3);
    n_tests += 3;
    if (ypush !== 1'b1) begin n_fail++; $display("FAIL pre_ypush got %b want 1", ypush); end
    if (yoff !== 6'd3) begin n_fail++; $display("FAIL pre_yoff got %0d want 3", yoff); end
    if (poff !== 6'd3) begin n_fail++; $display("FAIL pre_poff got %0d want 3", poff); end
    @(negedge Clk);
    frame_clk = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    n_tests += 5;
    if (push1 !== 1'b0) begin n_fail++; $display("FAIL rst_edge_push1 got %b want 0", push1); end
    if (push2 !== 1'b0) begin n_fail++; $display("FAIL rst_edge_push2 got %b want 0", push2); end
    if (ypush !== 1'b0) begin n_fail++; $display("FAIL rst_edge_ypush got %b want 0", ypush); end
    if (poff !== 6'd0) begin n_fail++; $display("FAIL rst_edge_poff got %0d want 0", poff); end
    if (yoff !== 6'd0) begin n_fail++; $display("FAIL rst_edge_yoff got %0d want 0", yoff); end
    Reset = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (ypush !== 1'b0) begin n_fail++; $display("FAIL post_rst_ypush got %b want 0", ypush); end
  endtask

  initial begin
    test_reset();
    test_purple_press();
    test_ramp();
    test_yellow();
    test_frame_hold();
    test_bounds();
    test_reset_on_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
